// File: rtl/apb_slave_mux.sv
// APB slave decoder and response mux: one-hot psel, routed slave response, error answer for unmapped slots.
// Define APB_SLAVE_MUX_TIMEOUT_EN to add the hung-slave timeout (counter, TOUT state, tout_flag).
module apb_slave_mux #(
  parameter int NUM_SLAVES  = 4,
  parameter int PADDR_W     = 16,
  parameter int DATA_W      = 32,
  parameter int SLV_SEL_LSB = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         hclk,
  input  logic                         hreset_n,
  input  logic                         psel_en,
  input  logic                         penable,
  input  logic [PADDR_W-1:0]           paddr,
  output logic                         pready_x,
  output logic                         pslverr_x,
  output logic [DATA_W-1:0]            prdata_x,
  output logic [NUM_SLAVES-1:0]        psel,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic                         status_clr,
  output logic                         err_flag,
  output logic                         tout_flag,
  output logic [PADDR_W-1:0]           err_addr
);

`ifdef APB_SLAVE_MUX_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, TOUT = 2'd2} state_t;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_r;
  logic       cnt_clr_s;
  logic       cnt_inc_s;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1} state_t;
  logic unused_tout_s;
  assign unused_tout_s = (TIMEOUT_CYC > 0);
`endif

  state_t                  state_r, state_nxt_s;
  logic [2:0]              idx_r, sel_idx_s;
  logic                    mapped_r, sel_mapped_s, setup_s, ld_s;
  logic [NUM_SLAVES-1:0]   acc_oh_s, psel_s;
  logic                    slv_ready_s, slv_err_s;
  logic [DATA_W-1:0]       slv_rdata_s, prdata_s;
  logic                    pready_s, pslverr_s, err_cap_s, tout_cap_s;
  logic                    err_flag_r, tout_flag_r;
  logic [PADDR_W-1:0]      err_addr_r;

  function automatic logic [NUM_SLAVES-1:0] onehot(input logic [2:0] idx, input logic en);
    logic [NUM_SLAVES-1:0] oh;
    for (int i = 0; i < NUM_SLAVES; i++) oh[i] = en && (32'(idx) == i);
    return oh;
  endfunction

  assign sel_idx_s    = paddr[SLV_SEL_LSB +: 3];
  assign sel_mapped_s = (32'(sel_idx_s) < NUM_SLAVES);
  assign setup_s      = psel_en & ~penable;
  assign acc_oh_s     = onehot(idx_r, mapped_r);

  // Route the held slave's response back towards the bridge.
  always_comb begin
    slv_ready_s = |(pready & acc_oh_s);
    slv_err_s   = |(pslverr & acc_oh_s);
    slv_rdata_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      slv_rdata_s = slv_rdata_s | (prdata[i*DATA_W +: DATA_W] & {DATA_W{acc_oh_s[i]}});
  end

  // Next-state and response decode.
  always_comb begin
    state_nxt_s = state_r;
    psel_s      = '0;
    pready_s    = 1'b0;
    pslverr_s   = 1'b0;
    prdata_s    = '0;
    ld_s        = 1'b0;
    err_cap_s   = 1'b0;
    tout_cap_s  = 1'b0;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (setup_s) begin
          psel_s      = onehot(sel_idx_s, sel_mapped_s);
          ld_s        = 1'b1;
          state_nxt_s = ACCESS;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
          cnt_clr_s   = 1'b1;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (!psel_en) begin
          state_nxt_s = IDLE;
        end else if (!mapped_r) begin
          pready_s    = 1'b1;
          pslverr_s   = 1'b1;
          err_cap_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          psel_s    = acc_oh_s;
          pready_s  = slv_ready_s;
          pslverr_s = slv_err_s;
          prdata_s  = slv_rdata_s;
          if (slv_ready_s) begin
            state_nxt_s = IDLE;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
          end else if (cnt_r == CNT_LAST) begin
            state_nxt_s = TOUT;
          end else begin
            cnt_inc_s   = 1'b1;
`else
          end else begin
`endif
            state_nxt_s = ACCESS;
          end
        end
      end
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
      TOUT: begin
        pready_s    = 1'b1;
        pslverr_s   = 1'b1;
        err_cap_s   = 1'b1;
        tout_cap_s  = 1'b1;
        state_nxt_s = IDLE;
      end
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state and held slave index.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_r  <= IDLE;
      idx_r    <= 3'd0;
      mapped_r <= 1'b0;
    end else if (ld_s) begin
      state_r  <= state_nxt_s;
      idx_r    <= sel_idx_s;
      mapped_r <= sel_mapped_s;
    end else begin
      state_r  <= state_nxt_s;
    end
  end

`ifdef APB_SLAVE_MUX_TIMEOUT_EN
  // Saturating access-phase cycle counter.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n)                           cnt_r <= 8'd0;
    else if (cnt_clr_s)                      cnt_r <= 8'd0;
    else if (cnt_inc_s && cnt_r != 8'hFF)    cnt_r <= cnt_r + 8'd1;
    else                                     cnt_r <= cnt_r;
  end
`endif

  // Sticky status; a capture in the same cycle as status_clr wins.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      err_flag_r  <= 1'b0;
      tout_flag_r <= 1'b0;
      err_addr_r  <= '0;
    end else begin
      err_flag_r  <= err_cap_s  ? 1'b1 : (status_clr ? 1'b0 : err_flag_r);
      tout_flag_r <= tout_cap_s ? 1'b1 : (status_clr ? 1'b0 : tout_flag_r);
      err_addr_r  <= err_cap_s  ? paddr : (status_clr ? '0 : err_addr_r);
    end
  end

  assign psel      = psel_s;
  assign pready_x  = pready_s;
  assign pslverr_x = pslverr_s;
  assign prdata_x  = prdata_s;
  assign err_flag  = err_flag_r;
  assign tout_flag = tout_flag_r;
  assign err_addr  = err_addr_r;

endmodule
